// File: rtl/memoria_resp.sv
// memoria_resp: word-addressed 32-bit RAM behind a simple request/response
// handshake with a fixed, parameterised wait time.
//
// Parameters
//   LATENCIA   wait cycles between accepting a request and completing it (0..15)
//   PROF_LOG2  log2 of the RAM depth in 32-bit words
//
// Ports
//   clock        system clock, everything changes on its rising edge
//   reset        synchronous active-high reset (RAM contents are kept)
//   Endereco     byte address of the request
//   DadoEscrita  write data
//   LeMem        read request strobe
//   EscreveMem   write request strobe (wins when both strobes are high)
//   DadoLido     registered read data, holds until the next successful read
//   Pronto       one-cycle completion pulse
//   Ocupado      high while a request is in progress
//   ErroAlinh    one-cycle misaligned-access flag, coincident with Pronto
//   Estado       current FSM state, for debug

module memoria_resp #(
  parameter int LATENCIA  = 1,
  parameter int PROF_LOG2 = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Endereco,
  input  logic [31:0] DadoEscrita,
  input  logic        LeMem,
  input  logic        EscreveMem,
  output logic [31:0] DadoLido,
  output logic        Pronto,
  output logic        Ocupado,
  output logic        ErroAlinh,
  output logic [1:0]  Estado
);

  localparam logic [3:0] LAT = 4'(LATENCIA);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    CONCLUI = 2'd2,
    ERRO    = 2'd3
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [3:0]             contador_q, contador_d;
  logic [PROF_LOG2-1:0]   indice_q, indice_d;
  logic [31:0]            dado_q, dado_d;
  logic                   escrita_q, escrita_d;
  logic [31:0]            dadoLido_q, dadoLido_d;
  logic [31:0]            mem_q [2**PROF_LOG2];

  logic                   aceita;
  logic                   commit;
  logic                   carregaLido;
  logic [PROF_LOG2-1:0]   indiceLeitura;
  logic [31:0]            leituraRam;

  // Upper address bits alias onto the same words by design.
  logic enderecoAlto_unused;
  assign enderecoAlto_unused = ^Endereco[31:PROF_LOG2+2];

  // Next-state logic. A request can be taken in OCIOSO and also on the edge
  // that leaves CONCLUI/ERRO, so back-to-back requests skip the idle cycle.
  // A pending write commits on the edge leaving CONCLUI; a read entering
  // CONCLUI on that same edge gets the new data through the forwarding mux.
  always_comb begin
    estado_d      = estado_q;
    contador_d    = contador_q;
    indice_d      = indice_q;
    dado_d        = dado_q;
    escrita_d     = escrita_q;
    dadoLido_d    = dadoLido_q;
    carregaLido   = 1'b0;
    indiceLeitura = indice_q;

    aceita = (estado_q != ESPERA) && (LeMem || EscreveMem);
    commit = (estado_q == CONCLUI) && escrita_q;

    case (estado_q)
      ESPERA: begin
        if (contador_q <= 4'd1) begin
          estado_d    = CONCLUI;
          contador_d  = 4'd0;
          carregaLido = !escrita_q;
        end else begin
          contador_d = contador_q - 4'd1;
        end
      end
      CONCLUI, ERRO: estado_d = OCIOSO;
      default: ;
    endcase

    if (aceita) begin
      indice_d   = Endereco[PROF_LOG2+1:2];
      dado_d     = DadoEscrita;
      escrita_d  = EscreveMem;
      contador_d = LAT;
      if (Endereco[1:0] != 2'b00) begin
        estado_d   = ERRO;
        contador_d = 4'd0;
      end else if (LAT != 4'd0) begin
        estado_d = ESPERA;
      end else begin
        estado_d      = CONCLUI;
        carregaLido   = !EscreveMem;
        indiceLeitura = Endereco[PROF_LOG2+1:2];
      end
    end

    leituraRam = (commit && (indiceLeitura == indice_q)) ? dado_q : mem_q[indiceLeitura];
    if (carregaLido) begin
      dadoLido_d = leituraRam;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      contador_q <= 4'd0;
      indice_q   <= '0;
      dado_q     <= 32'd0;
      escrita_q  <= 1'b0;
      dadoLido_q <= 32'd0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      indice_q   <= indice_d;
      dado_q     <= dado_d;
      escrita_q  <= escrita_d;
      dadoLido_q <= dadoLido_d;
    end
  end

  // RAM has no reset; a reset in CONCLUI suppresses the pending commit.
  always_ff @(posedge clock) begin
    if (!reset && commit) begin
      mem_q[indice_q] <= dado_q;
    end
  end

  assign DadoLido  = dadoLido_q;
  assign Pronto    = (estado_q == CONCLUI) || (estado_q == ERRO);
  assign Ocupado   = (estado_q != OCIOSO);
  assign ErroAlinh = (estado_q == ERRO);
  assign Estado    = estado_q;

endmodule

// File: tb/tb_memoria_resp.sv
// Testbench for memoria_resp: one instance with LATENCIA=1 (unit 0) and one
// with LATENCIA=0 (unit 1). A word-level reference model (array of words plus
// the last successful read value) predicts every response.

module tb_memoria_resp;

  localparam int PROF = 256;

  logic        clock;
  logic        reset       [2];
  logic [31:0] endereco    [2];
  logic [31:0] dadoEscrita [2];
  logic        leMem       [2];
  logic        escreveMem  [2];
  logic [31:0] dadoLido    [2];
  logic        pronto      [2];
  logic        ocupado     [2];
  logic        erroAlinh   [2];
  logic [1:0]  estado      [2];

  int vectors = 0;
  int miscompares = 0;
  int lat [2] = '{1, 0};

  // Reference model
  logic [31:0] refRam    [2][PROF];
  bit          conhecido [2][PROF];
  logic [31:0] refLido   [2];
  bit          lidoValido[2];

  memoria_resp #(.LATENCIA(1), .PROF_LOG2(8)) dut0 (
    .clock(clock), .reset(reset[0]), .Endereco(endereco[0]), .DadoEscrita(dadoEscrita[0]),
    .LeMem(leMem[0]), .EscreveMem(escreveMem[0]), .DadoLido(dadoLido[0]), .Pronto(pronto[0]),
    .Ocupado(ocupado[0]), .ErroAlinh(erroAlinh[0]), .Estado(estado[0])
  );

  memoria_resp #(.LATENCIA(0), .PROF_LOG2(8)) dut1 (
    .clock(clock), .reset(reset[1]), .Endereco(endereco[1]), .DadoEscrita(dadoEscrita[1]),
    .LeMem(leMem[1]), .EscreveMem(escreveMem[1]), .DadoLido(dadoLido[1]), .Pronto(pronto[1]),
    .Ocupado(ocupado[1]), .ErroAlinh(erroAlinh[1]), .Estado(estado[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          unidade;
    logic        le;
    logic        es;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expLido;
    logic        expErro;
    string       nome;
  } vetor_t;

  vetor_t tabela [12];

  task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    vectors++;
    if (atual !== esperado) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nome, atual, esperado);
    end
  endtask

  // Runs one request from acceptance to the following idle cycle, checking
  // every cycle against the timing rules and the model.
  task automatic applyStimulus(input int u, input logic le, input logic es,
                               input logic [31:0] addr, input logic [31:0] data,
                               output logic [31:0] lidoOut, output logic erroOut);
    bit mis;
    int n;
    int idx;
    mis = (addr[1:0] != 2'b00);
    idx = int'(addr[9:2]);
    n   = mis ? 1 : lat[u] + 1;
    @(negedge clock);
    endereco[u]    = addr;
    dadoEscrita[u] = data;
    leMem[u]       = le;
    escreveMem[u]  = es;
    @(negedge clock);
    leMem[u]      = 1'b0;
    escreveMem[u] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clock);
      checkOutput($sformatf("u%0d pronto c%0d", u, k), 32'(pronto[u]), 32'(k == n));
      checkOutput($sformatf("u%0d ocupado c%0d", u, k), 32'(ocupado[u]), 32'd1);
      checkOutput($sformatf("u%0d erro c%0d", u, k), 32'(erroAlinh[u]), 32'(mis && k == n));
      checkOutput($sformatf("u%0d estado c%0d", u, k), 32'(estado[u]),
                  (k < n) ? 32'd1 : (mis ? 32'd3 : 32'd2));
      if (k == n) begin
        if (!mis && !es) begin
          refLido[u]    = refRam[u][idx];
          lidoValido[u] = conhecido[u][idx];
        end
        if (lidoValido[u])
          checkOutput($sformatf("u%0d dadoLido @%08h", u, addr), dadoLido[u], refLido[u]);
        if (!mis && es) begin
          refRam[u][idx]    = data;
          conhecido[u][idx] = 1'b1;
        end
      end
    end
    lidoOut = dadoLido[u];
    erroOut = erroAlinh[u];
    @(negedge clock);
    checkOutput($sformatf("u%0d ocioso ocupado", u), 32'(ocupado[u]), 32'd0);
    checkOutput($sformatf("u%0d ocioso estado", u), 32'(estado[u]), 32'd0);
  endtask

  task automatic checkResetState(input int u);
    checkOutput($sformatf("u%0d rst estado", u), 32'(estado[u]), 32'd0);
    checkOutput($sformatf("u%0d rst pronto", u), 32'(pronto[u]), 32'd0);
    checkOutput($sformatf("u%0d rst ocupado", u), 32'(ocupado[u]), 32'd0);
    checkOutput($sformatf("u%0d rst erro", u), 32'(erroAlinh[u]), 32'd0);
    checkOutput($sformatf("u%0d rst dadoLido", u), dadoLido[u], 32'd0);
  endtask

  initial begin
    logic [31:0] lido;
    logic        erro;
    int          prontos;

    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; endereco[u] = '0; dadoEscrita[u] = '0;
      leMem[u] = 1'b0; escreveMem[u] = 1'b0;
      refLido[u] = 32'd0; lidoValido[u] = 1'b1;
      for (int i = 0; i < PROF; i++) conhecido[u][i] = 1'b0;
    end

    // Reset with a strobe pending: the request must be dropped.
    leMem[0] = 1'b1;
    repeat (2) @(negedge clock);
    checkResetState(0);
    checkResetState(1);
    leMem[0] = 1'b0;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    tabela[0]  = '{0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, "wr 0x10"};
    tabela[1]  = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, "rd 0x10"};
    tabela[2]  = '{1, 1'b0, 1'b1, 32'h04,  32'h12345678, 32'h0,        1'b0, "lat0 wr 0x04"};
    tabela[3]  = '{1, 1'b1, 1'b0, 32'h04,  32'h0,        32'h12345678, 1'b0, "lat0 rd 0x04"};
    tabela[4]  = '{0, 1'b1, 1'b0, 32'h402, 32'h0,        32'hDEADBEEF, 1'b1, "rd misaligned"};
    tabela[5]  = '{0, 1'b0, 1'b1, 32'h0,   32'h11111111, 32'hDEADBEEF, 1'b0, "wr 0x0"};
    tabela[6]  = '{0, 1'b0, 1'b1, 32'h400, 32'h22222222, 32'hDEADBEEF, 1'b0, "wr 0x400 alias"};
    tabela[7]  = '{0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h22222222, 1'b0, "rd 0x0 alias"};
    tabela[8]  = '{0, 1'b1, 1'b1, 32'h30,  32'hA5A5A5A5, 32'h22222222, 1'b0, "both strobes"};
    tabela[9]  = '{0, 1'b1, 1'b0, 32'h30,  32'h0,        32'hA5A5A5A5, 1'b0, "rd 0x30"};
    tabela[10] = '{0, 1'b0, 1'b1, 32'h12,  32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, "wr misaligned"};
    tabela[11] = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, "rd 0x10 intact"};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tabela[i].unidade, tabela[i].le, tabela[i].es,
                    tabela[i].addr, tabela[i].data, lido, erro);
      checkOutput({tabela[i].nome, " lido"}, lido, tabela[i].expLido);
      checkOutput({tabela[i].nome, " erro"}, 32'(erro), 32'(tabela[i].expErro));
    end

    // LeMem pulsed while in ESPERA must not start a second request.
    @(negedge clock);
    endereco[0] = 32'h10; leMem[0] = 1'b1;
    @(negedge clock);
    checkOutput("pulse espera estado", 32'(estado[0]), 32'd1);
    endereco[0] = 32'h0;
    prontos = 0;
    @(negedge clock);
    leMem[0] = 1'b0;
    if (pronto[0]) prontos++;
    repeat (5) begin
      @(negedge clock);
      if (pronto[0]) prontos++;
    end
    checkOutput("pulse espera prontos", 32'(prontos), 32'd1);
    checkOutput("pulse espera lido", dadoLido[0], 32'hDEADBEEF);
    refLido[0] = 32'hDEADBEEF;

    // Reset during ESPERA of a write aborts it without touching RAM.
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h01020304, lido, erro);
    @(negedge clock);
    endereco[0] = 32'h20; dadoEscrita[0] = 32'hCAFEF00D; escreveMem[0] = 1'b1;
    @(negedge clock);
    escreveMem[0] = 1'b0;
    checkOutput("abort estado espera", 32'(estado[0]), 32'd1);
    reset[0] = 1'b1;
    @(negedge clock);
    checkResetState(0);
    reset[0] = 1'b0;
    refLido[0] = 32'd0; lidoValido[0] = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, lido, erro);
    checkOutput("abort rd 0x20", lido, 32'h01020304);

    // Back-to-back at LATENCIA=0: read accepted on the edge leaving the
    // write's CONCLUI must see the freshly committed word.
    @(negedge clock);
    endereco[1] = 32'h50; dadoEscrita[1] = 32'h5A5A0001; escreveMem[1] = 1'b1;
    @(negedge clock);
    escreveMem[1] = 1'b0; leMem[1] = 1'b1;
    checkOutput("b2b wr estado", 32'(estado[1]), 32'd2);
    @(negedge clock);
    leMem[1] = 1'b0;
    checkOutput("b2b rd estado", 32'(estado[1]), 32'd2);
    checkOutput("b2b rd ocupado", 32'(ocupado[1]), 32'd1);
    checkOutput("b2b rd lido", dadoLido[1], 32'h5A5A0001);
    @(negedge clock);
    checkOutput("b2b ocioso", 32'(estado[1]), 32'd0);
    refRam[1][20] = 32'h5A5A0001; conhecido[1][20] = 1'b1;
    refLido[1] = 32'h5A5A0001; lidoValido[1] = 1'b1;

    // Randomised traffic against the model, small address window so reads
    // frequently hit written words, high bits random to exercise aliasing.
    for (int i = 0; i < 300; i++) begin
      int u;
      int op;
      logic [31:0] a;
      u  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      a  = $urandom;
      a[9:6] = 4'd0;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      applyStimulus(u, op != 1, op != 0, a, $urandom, lido, erro);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
